// File: rtl/pong_pkg.sv
// Shared types and default constants for the BASPONG match logic.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } match_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } winner_t;

  localparam int unsigned DEF_WIN_SCORE     = 9;
  localparam int unsigned DEF_POINT_DELAY   = 50_000_000;
  localparam int unsigned DEF_SERVE_TIMEOUT = 150_000_000;
  localparam int unsigned DEF_CNT_W         = 28;

endpackage

// File: rtl/rise_det.sv
// Single-cycle rising-edge pulse from a level that is already clk-synchronous.
module rise_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  // History flop holding the level seen on the previous edge.
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/match_ctrl.sv
// Match sequencer: converts level score flags into one point per rally,
// gates ball motion and tracks serve direction, scores and the winner.
module match_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = DEF_WIN_SCORE,
  parameter int unsigned POINT_DELAY   = DEF_POINT_DELAY,
  parameter int unsigned SERVE_TIMEOUT = DEF_SERVE_TIMEOUT,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       start_ball,
  input  logic       score_checker1,
  input  logic       score_checker2,
  output logic [3:0] player1_score,
  output logic [3:0] player2_score,
  output logic       ball_enable,
  output logic       ball_recenter,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [2:0] state_o
);

  match_state_t     state, state_n;
  winner_t          win_q, win_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       p1, p1_n, p2, p2_n;
  logic             dir, dir_n;
  logic             start_rise, ball_rise, s1_rise, s2_rise;

  rise_det u_start (.clk(clk), .reset(reset), .level(start),          .rise(start_rise));
  rise_det u_ball  (.clk(clk), .reset(reset), .level(start_ball),     .rise(ball_rise));
  rise_det u_s1    (.clk(clk), .reset(reset), .level(score_checker1), .rise(s1_rise));
  rise_det u_s2    (.clk(clk), .reset(reset), .level(score_checker2), .rise(s2_rise));

  // State, counter, score and decoded-output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      p1            <= '0;
      p2            <= '0;
      dir           <= 1'b0;
      win_q         <= WIN_NONE;
      ball_enable   <= 1'b0;
      ball_recenter <= 1'b1;
      game_over     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      p1            <= p1_n;
      p2            <= p2_n;
      dir           <= dir_n;
      win_q         <= win_n;
      ball_enable   <= (state_n == PLAY);
      ball_recenter <= (state_n == IDLE) || (state_n == SERVE) || (state_n == POINT);
      game_over     <= (state_n == OVER);
    end
  end

  // Next-state, counter and score logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p1_n    = p1;
    p2_n    = p2;
    dir_n   = dir;
    win_n   = win_q;
    // A start rise begins a fresh match from every state, so it is handled
    // once ahead of the per-state decode and overrides any score rise.
    if (start_rise) begin
      state_n = SERVE;
      cnt_n   = '0;
      p1_n    = '0;
      p2_n    = '0;
      dir_n   = 1'b0;
      win_n   = WIN_NONE;
    end else begin
      unique case (state)
        IDLE: ;
        SERVE: begin
          if (ball_rise || cnt == CNT_W'(SERVE_TIMEOUT - 1)) begin
            state_n = PLAY;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          if (s1_rise || s2_rise) begin
            state_n = POINT;
            cnt_n   = '0;
            if (s1_rise && !s2_rise) begin
              if (p1 < 4'(WIN_SCORE)) p1_n = p1 + 4'd1;
              dir_n = 1'b1;
            end else if (s2_rise && !s1_rise) begin
              if (p2 < 4'(WIN_SCORE)) p2_n = p2 + 4'd1;
              dir_n = 1'b0;
            end
          end
        end
        POINT: begin
          if (cnt == CNT_W'(POINT_DELAY - 1)) begin
            cnt_n = '0;
            if (p1 == 4'(WIN_SCORE)) begin
              state_n = OVER;
              win_n   = WIN_P1;
            end else if (p2 == 4'(WIN_SCORE)) begin
              state_n = OVER;
              win_n   = WIN_P2;
            end else begin
              state_n = SERVE;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        OVER: ;
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign player1_score = p1;
  assign player2_score = p2;
  assign serve_dir     = dir;
  assign winner        = win_q;
  assign state_o       = state;

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed vector table, hand-written
// match sequences and randomized stimulus against a rule-level model.
module tb_match_ctrl;

  localparam int WIN = 3;
  localparam int PD  = 4;
  localparam int TO  = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st = 1'b0, sb = 1'b0, s1 = 1'b0, s2 = 1'b0;
  logic [3:0] p1_o, p2_o;
  logic       be_o, rc_o, dir_o, go_o;
  logic [1:0] win_o;
  logic [2:0] state_o;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  match_ctrl #(.WIN_SCORE(WIN), .POINT_DELAY(PD), .SERVE_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(rst), .start(st), .start_ball(sb),
    .score_checker1(s1), .score_checker2(s2),
    .player1_score(p1_o), .player2_score(p2_o),
    .ball_enable(be_o), .ball_recenter(rc_o), .serve_dir(dir_o),
    .game_over(go_o), .winner(win_o), .state_o(state_o)
  );

  // Reference model: phase number, time spent in phase, scores, history.
  int m_ph, m_t, m_p1, m_p2, m_dir, m_win;
  bit h_st, h_sb, h_s1, h_s2;

  task automatic model_edge();
    bit r_st, r_sb, r_s1, r_s2;
    if (rst) begin
      m_ph = 0; m_t = 0; m_p1 = 0; m_p2 = 0; m_dir = 0; m_win = 0;
      h_st = 0; h_sb = 0; h_s1 = 0; h_s2 = 0;
      return;
    end
    r_st = st && !h_st; r_sb = sb && !h_sb; r_s1 = s1 && !h_s1; r_s2 = s2 && !h_s2;
    h_st = st; h_sb = sb; h_s1 = s1; h_s2 = s2;
    m_t++;
    if (r_st) begin
      m_ph = 1; m_t = 0; m_p1 = 0; m_p2 = 0; m_dir = 0; m_win = 0;
    end else if (m_ph == 1) begin
      if (r_sb || m_t == TO) begin m_ph = 2; m_t = 0; end
    end else if (m_ph == 2) begin
      if (r_s1 || r_s2) begin
        if (r_s1 && !r_s2) begin m_p1 = (m_p1 + 1 > WIN) ? WIN : m_p1 + 1; m_dir = 1; end
        if (r_s2 && !r_s1) begin m_p2 = (m_p2 + 1 > WIN) ? WIN : m_p2 + 1; m_dir = 0; end
        m_ph = 3; m_t = 0;
      end
    end else if (m_ph == 3) begin
      if (m_t == PD) begin
        m_t = 0;
        if (m_p1 == WIN)      begin m_ph = 4; m_win = 1; end
        else if (m_p2 == WIN) begin m_ph = 4; m_win = 2; end
        else                  m_ph = 1;
      end
    end
  endtask

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One clock edge, model update, then compare all outputs to the model.
  task automatic step();
    int exp_v, act_v;
    @(posedge clk);
    model_edge();
    #1;
    exp_v = {m_ph[2:0], m_p1[3:0], m_p2[3:0], (m_ph == 2), (m_ph == 0 || m_ph == 1 || m_ph == 3),
             m_dir[0], (m_ph == 4), m_win[1:0]};
    act_v = {state_o, p1_o, p2_o, be_o, rc_o, dir_o, go_o, win_o};
    check("model", act_v, exp_v);
  endtask

  typedef struct {
    bit rst, st, sb, s1, s2;
    int es, ep1, ep2, edir;
  } vec_t;
  vec_t vq[$];

  task automatic add(bit r, bit a, bit b, bit c, bit d, int es, int ep1, int ep2, int edir);
    vec_t v;
    v.rst = r; v.st = a; v.sb = b; v.s1 = c; v.s2 = d;
    v.es = es; v.ep1 = ep1; v.ep2 = ep2; v.edir = edir;
    vq.push_back(v);
  endtask

  task automatic rally(int who);
    sb = 1; step(); sb = 0;
    check("rally_play", state_o, 2);
    if (who == 1) s1 = 1; else s2 = 1;
    step(); s1 = 0; s2 = 0;
    check("rally_point", state_o, 3);
    repeat (PD) step();
  endtask

  initial begin
    // Plan items 1-4 as per-cycle vectors: inputs before the edge, outputs after.
    add(1,0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0, 1,0,0,0);
    add(0,1,0,0,0, 1,0,0,0);
    add(0,0,0,0,0, 1,0,0,0);
    add(0,0,1,0,0, 2,0,0,0);
    add(0,0,1,0,0, 2,0,0,0);
    for (int i = 0; i < 5; i++) add(0,0,0,1,0, (i < 4) ? 3 : 1, 1,0,1);
    add(0,0,0,1,0, 1,1,0,1);
    for (int i = 0; i < 8; i++) add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,0, 2,1,0,1);
    add(0,0,0,1,1, 3,1,0,1);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 3,1,0,1);
    add(0,0,0,0,0, 1,1,0,1);
    add(0,0,0,0,1, 1,1,0,1);
    add(0,0,0,0,0, 1,1,0,1);

    foreach (vq[i]) begin
      rst = vq[i].rst; st = vq[i].st; sb = vq[i].sb; s1 = vq[i].s1; s2 = vq[i].s2;
      step();
      check("vec_state", state_o, vq[i].es);
      check("vec_p1", p1_o, vq[i].ep1);
      check("vec_p2", p2_o, vq[i].ep2);
      check("vec_dir", dir_o, vq[i].edir);
      if (i == 1) begin
        check("reset_be", be_o, 0);
        check("reset_rc", rc_o, 1);
      end
      if (i == 6) check("play_be", be_o, 1);
    end
    s2 = 0;

    // Restart mid-match, then player 2 wins three rallies.
    st = 1; step(); st = 0;
    check("restart_state", state_o, 1);
    check("restart_p1", p1_o, 0);
    rally(2); check("p2_after1", p2_o, 1); check("serve_after1", state_o, 1);
    rally(2);
    rally(2);
    check("over_state", state_o, 4);
    check("over_p2", p2_o, 3);
    check("over_winner", win_o, 2);
    check("over_flag", go_o, 1);
    s1 = 1; step(); s1 = 0; step(); s2 = 1; step(); s2 = 0; step();
    check("frozen_p1", p1_o, 0);
    check("frozen_p2", p2_o, 3);
    check("frozen_state", state_o, 4);
    st = 1; step(); st = 0;
    check("newgame_state", state_o, 1);
    check("newgame_p2", p2_o, 0);
    check("newgame_winner", win_o, 0);

    // Reset while in PLAY with player 1 on two points.
    rally(1); rally(1);
    check("pre_reset_p1", p1_o, 2);
    sb = 1; step(); sb = 0;
    rst = 1; step();
    check("midreset_state", state_o, 0);
    check("midreset_p1", p1_o, 0);
    check("midreset_be", be_o, 0);
    rst = 0; step();

    // Randomized traffic compared every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 59) == 0) ? 1'b1 : (st && $urandom_range(0, 1) == 1);
      sb  = $urandom_range(0, 5) == 0;
      s1  = $urandom_range(0, 3) == 0;
      s2  = $urandom_range(0, 3) == 0;
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
